// File: rtl/event_delay_timer.sv
// event_delay_timer: N-channel armed trigger detector with programmable delay and one-cycle fire pulse
module event_delay_timer #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    sig_in,
    input  logic [N-1:0]    arm,
    input  logic [N-1:0]    cancel,
    input  logic [2*N-1:0]  mode,
    input  logic [DW*N-1:0] delay,
    output logic [N-1:0]    fire,
    output logic            fire_any,
    output logic [N-1:0]    busy,
    output logic [N-1:0]    overrun
);
    typedef enum logic [1:0] {IDLE, ARMED, COUNT} state_t;
    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};
    logic [N-1:0] sig_q;
    // previous-cycle copy of every monitored signal, kept in all states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= '0;
        else        sig_q <= sig_in;
    end
    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t        state_q, state_d;
        logic [DW-1:0] cnt_q, cnt_d, dly_q, dly_d;
        logic [1:0]    mode_q, mode_d;
        logic          ovr_q, ovr_d, fire_q, fire_d;
        logic          pos, neg, chg, hit;
        assign pos = sig_in[i] & ~sig_q[i];
        assign neg = ~sig_in[i] & sig_q[i];
        assign chg = sig_in[i] ^ sig_q[i];
        assign hit = (mode_q == 2'd0) ? pos :
                     (mode_q == 2'd1) ? neg :
                     (mode_q == 2'd2) ? chg : sig_in[i];
        // channel next state: cancel wins, arm only accepted from IDLE/ARMED, count down then fire
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            dly_d   = dly_q;
            mode_d  = mode_q;
            ovr_d   = ovr_q;
            fire_d  = 1'b0;
            if (cancel[i]) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    IDLE: if (arm[i]) begin
                        state_d = ARMED;
                        mode_d  = mode[2*i +: 2];
                        dly_d   = delay[DW*i +: DW];
                        ovr_d   = 1'b0;
                    end
                    ARMED: if (arm[i]) begin
                        mode_d = mode[2*i +: 2];
                        dly_d  = delay[DW*i +: DW];
                    end else if (hit) begin
                        state_d = COUNT;
                        cnt_d   = dly_q;
                    end
                    COUNT: begin
                        ovr_d = ovr_q | hit;
                        if (cnt_q == '0) begin
                            fire_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q - ONE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
        // channel registers; reset drops any pending fire
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                dly_q   <= '0;
                mode_q  <= '0;
                ovr_q   <= 1'b0;
                fire_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                dly_q   <= dly_d;
                mode_q  <= mode_d;
                ovr_q   <= ovr_d;
                fire_q  <= fire_d;
            end
        end
        assign fire[i]    = fire_q;
        assign busy[i]    = state_q != IDLE;
        assign overrun[i] = ovr_q;
    end
    assign fire_any = |fire;
endmodule

// File: tb/tb_event_delay_timer.sv
// tb_event_delay_timer: directed self-checking bench for event_delay_timer
module tb_event_delay_timer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  sig_in, arm, cancel;
    logic [7:0]  mode;
    logic [31:0] delay;
    logic [3:0]  fire, busy, overrun;
    logic        fire_any;
    logic [3:0]  seen;
    int checks = 0;
    int failures = 0;

    event_delay_timer #(.N(4), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .arm(arm), .cancel(cancel),
        .mode(mode), .delay(delay), .fire(fire), .fire_any(fire_any),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setch(input int ch, input logic [1:0] m, input logic [7:0] d);
        mode[2*ch +: 2]  = m;
        delay[8*ch +: 8] = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; sig_in = '0; arm = '0; cancel = '0; mode = '0; delay = '0;
        #3;
        chk("rst_fire", fire, 4'h0);
        chk("rst_busy", busy, 4'h0);
        chk("rst_overrun", overrun, 4'h0);
        #9 rst_n = 1'b1;
        cyc(1);
        chk("post_rst_busy", busy, 4'h0);
        chk("post_rst_fire_any", fire_any, 1'b0);

        // ch0 posedge, delay 3: fire 4 edges after the event edge
        arm[0] = 1'b1; setch(0, 2'd0, 8'd3);
        cyc(1); arm = '0;
        chk("a_armed_busy", busy, 4'h1);
        cyc(7); sig_in[0] = 1'b1;
        cyc(1);
        chk("a_event_busy", busy, 4'h1);
        cyc(3);
        chk("a_e3_fire", fire, 4'h0);
        chk("a_e3_busy", busy, 4'h1);
        cyc(1);
        chk("a_e4_fire", fire, 4'h1);
        chk("a_e4_fire_any", fire_any, 1'b1);
        chk("a_e4_busy", busy, 4'h0);
        cyc(1);
        chk("a_e5_fire", fire, 4'h0);
        chk("a_e5_fire_any", fire_any, 1'b0);

        // ch1 negedge delay 0, ch2 any-change delay 5 with an overrun toggle
        arm[1] = 1'b1; arm[2] = 1'b1; setch(1, 2'd1, 8'd0); setch(2, 2'd2, 8'd5); sig_in[1] = 1'b1;
        cyc(1); arm = '0;
        cyc(1); sig_in[1] = 1'b0; sig_in[2] = 1'b1;
        cyc(1);
        chk("b_e0_busy", busy, 4'h6);
        chk("b_e0_fire", fire, 4'h0);
        cyc(1);
        chk("b_e1_fire", fire, 4'h2);
        chk("b_e1_busy", busy, 4'h4);
        chk("b_e1_overrun", overrun, 4'h0);
        sig_in[2] = 1'b0;
        cyc(1);
        chk("b_e2_overrun", overrun, 4'h4);
        chk("b_e2_fire", fire, 4'h0);
        cyc(3);
        chk("b_e5_fire", fire, 4'h0);
        cyc(1);
        chk("b_e6_fire", fire, 4'h4);
        chk("b_e6_fire_any", fire_any, 1'b1);
        chk("b_e6_busy", busy, 4'h0);
        chk("b_e6_overrun", overrun, 4'h4);
        cyc(2);
        chk("b_overrun_sticky", overrun, 4'h4);
        arm[2] = 1'b1;
        cyc(1); arm = '0;
        chk("b_rearm_clears_overrun", overrun, 4'h0);
        chk("b_rearm_busy", busy, 4'h4);
        cancel[2] = 1'b1;
        cyc(1); cancel = '0;
        chk("b_cancel_busy", busy, 4'h0);

        // ch3 level mode with input already high, delay 1
        sig_in[3] = 1'b1;
        cyc(2);
        arm[3] = 1'b1; setch(3, 2'd3, 8'd1);
        cyc(1); arm = '0;
        chk("c_armed_busy", busy, 4'h8);
        cyc(1);
        chk("c_a1_fire", fire, 4'h0);
        cyc(1);
        chk("c_a2_fire", fire, 4'h0);
        cyc(1);
        chk("c_a3_fire", fire, 4'h8);
        // posedge coincident with the arming edge is not captured
        sig_in[3] = 1'b0;
        cyc(2);
        arm[3] = 1'b1; setch(3, 2'd0, 8'd1); sig_in[3] = 1'b1;
        cyc(1); arm = '0;
        seen = '0;
        for (int k = 0; k < 4; k++) begin cyc(1); seen |= fire; end
        chk("c_coincident_no_fire", seen, 4'h0);
        chk("c_coincident_still_armed", busy, 4'h8);
        cancel[3] = 1'b1;
        cyc(1); cancel = '0;

        // ch0 long delay cancelled mid-count
        sig_in[0] = 1'b0;
        cyc(1);
        arm[0] = 1'b1; setch(0, 2'd0, 8'd200);
        cyc(1); arm = '0; sig_in[0] = 1'b1;
        cyc(1);
        cyc(150);
        chk("d_midcount_busy", busy, 4'h1);
        cancel[0] = 1'b1;
        cyc(1); cancel = '0;
        chk("d_cancel_busy", busy, 4'h0);
        seen = '0;
        for (int k = 0; k < 60; k++) begin cyc(1); seen |= fire | busy; end
        chk("d_cancel_no_fire", seen, 4'h0);

        // same again, with an overrun, then async reset mid-count
        sig_in[0] = 1'b0;
        cyc(1);
        arm[0] = 1'b1;
        cyc(1); arm = '0; sig_in[0] = 1'b1;
        cyc(1);
        sig_in[0] = 1'b0;
        cyc(1); sig_in[0] = 1'b1;
        cyc(1);
        chk("d_overrun_set", overrun, 4'h1);
        cyc(148);
        rst_n = 1'b0;
        #1;
        chk("d_rst_busy", busy, 4'h0);
        chk("d_rst_overrun", overrun, 4'h0);
        chk("d_rst_fire_any", fire_any, 1'b0);
        cyc(1); rst_n = 1'b1;
        seen = '0;
        for (int k = 0; k < 60; k++) begin cyc(1); seen |= fire | busy; end
        chk("d_rst_no_fire", seen, 4'h0);

        // re-arm in ARMED replaces delay; arm in COUNT ignored; arm in fire cycle accepted
        sig_in = '0;
        cyc(2);
        arm[0] = 1'b1; setch(0, 2'd0, 8'd2);
        cyc(1); setch(0, 2'd0, 8'd7);
        cyc(1); arm = '0;
        cyc(1); sig_in[0] = 1'b1;
        cyc(1);
        cyc(2);
        arm[0] = 1'b1; setch(0, 2'd0, 8'd1);
        cyc(1); arm = '0;
        cyc(4);
        chk("e_e7_fire", fire, 4'h0);
        chk("e_e7_busy", busy, 4'h1);
        cyc(1);
        chk("e_e8_fire", fire, 4'h1);
        chk("e_e8_busy", busy, 4'h0);
        arm[0] = 1'b1; setch(0, 2'd0, 8'd3);
        cyc(1); arm = '0;
        chk("e_fire_cycle_arm_busy", busy, 4'h1);
        cancel[0] = 1'b1;
        cyc(1); cancel = '0;

        // maximum delay 255 on ch1: no wrap
        arm[1] = 1'b1; setch(1, 2'd0, 8'd255);
        cyc(1); arm = '0; sig_in[1] = 1'b1;
        cyc(1);
        cyc(255);
        chk("f_max_e255_fire", fire, 4'h0);
        chk("f_max_e255_busy", busy, 4'h2);
        cyc(1);
        chk("f_max_e256_fire", fire, 4'h2);

        // all four channels fire on the same edge
        sig_in = '0;
        cyc(1);
        arm = 4'hF;
        for (int c = 0; c < 4; c++) setch(c, 2'd0, 8'd4);
        cyc(1); arm = '0; sig_in = 4'hF;
        cyc(1);
        cyc(4);
        chk("g_e4_fire", fire, 4'h0);
        cyc(1);
        chk("g_e5_fire", fire, 4'hF);
        chk("g_e5_fire_any", fire_any, 1'b1);
        chk("g_e5_busy", busy, 4'h0);
        cyc(1);
        chk("g_e6_fire", fire, 4'h0);
        chk("g_e6_fire_any", fire_any, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
